// File: rtl/mem_access_stage.sv
// MEM pipeline stage: consumes the EXE/MEM register outputs, performs
// word-addressed data memory accesses with a fixed multi-cycle latency,
// and drives the MEM/WB pipeline register. While an access is in flight,
// upstream stages are frozen via stall and MEM/WB receives bubbles.
module mem_access_stage #(
    parameter int DEPTH_LOG2  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wregin,
    input  logic        m2regin,
    input  logic        wmemin,
    input  logic [4:0]  RdRtin,
    input  logic [31:0] aluresultin,
    input  logic [31:0] qbin,
    output logic        stall,
    output logic        wregout,
    output logic        m2regout,
    output logic [4:0]  RdRtout,
    output logic [31:0] aluresultout,
    output logic [31:0] mdataout,
    output logic        misalignout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            wreg_q, wreg_d;
    logic            m2reg_q, m2reg_d;
    logic [4:0]      rdrt_q, rdrt_d;
    logic [31:0]     alures_q, alures_d;
    logic [31:0]     mdata_q, mdata_d;
    logic            misalign_q, misalign_d;

    logic [31:0]     mem [DEPTH];

    logic                  access;
    logic                  retire;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] idx;

    // Decode the current instruction and decide whether it retires this cycle.
    // Non-access instructions and single-cycle accesses retire straight from
    // IDLE; multi-cycle accesses retire on the last BUSY count.
    always_comb begin
        access = m2regin | wmemin;
        idx    = aluresultin[DEPTH_LOG2+1:2];
        if (state_q == BUSY) begin
            retire = (cnt_q == CNT_LAST);
        end else begin
            retire = !access || (MEM_LATENCY == 1);
        end
        stall  = !rst && !retire;
        mem_we = !rst && retire && wmemin;
    end

    // Next-state, counter and MEM/WB contents; a bubble (all zero) unless retiring.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wreg_d     = 1'b0;
        m2reg_d    = 1'b0;
        rdrt_d     = 5'd0;
        alures_d   = 32'd0;
        mdata_d    = 32'd0;
        misalign_d = 1'b0;
        if (retire) begin
            state_d    = IDLE;
            cnt_d      = '0;
            wreg_d     = wregin;
            m2reg_d    = m2regin;
            rdrt_d     = RdRtin;
            alures_d   = aluresultin;
            // Read returns pre-write contents, so a combined load+store sees old data.
            mdata_d    = m2regin ? mem[idx] : 32'd0;
            misalign_d = access && (aluresultin[1:0] != 2'b00);
        end else if (state_q == IDLE) begin
            state_d = BUSY;
            cnt_d   = CW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Register FSM state, counter and MEM/WB outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wreg_q     <= 1'b0;
            m2reg_q    <= 1'b0;
            rdrt_q     <= 5'd0;
            alures_q   <= 32'd0;
            mdata_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wreg_q     <= wreg_d;
            m2reg_q    <= m2reg_d;
            rdrt_q     <= rdrt_d;
            alures_q   <= alures_d;
            mdata_q    <= mdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Data memory write; contents survive reset and a store cut off by reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= qbin;
        end
    end

    assign wregout      = wreg_q;
    assign m2regout     = m2reg_q;
    assign RdRtout      = rdrt_q;
    assign aluresultout = alures_q;
    assign mdataout     = mdata_q;
    assign misalignout  = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: one instance at MEM_LATENCY=2 and one
// at MEM_LATENCY=1, with a scoreboard of expected MEM/WB contents and a
// bench-side memory model.
module tb_mem_access_stage;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        a_wreg, a_m2reg, a_wmem;
    logic [4:0]  a_rd;
    logic [31:0] a_alu, a_qb;
    logic        a_stall, a_wreg_o, a_m2reg_o, a_mis_o;
    logic [4:0]  a_rd_o;
    logic [31:0] a_alu_o, a_mdata_o;

    logic        b_wreg, b_m2reg, b_wmem;
    logic [4:0]  b_rd;
    logic [31:0] b_alu, b_qb;
    logic        b_stall, b_wreg_o, b_m2reg_o, b_mis_o;
    logic [4:0]  b_rd_o;
    logic [31:0] b_alu_o, b_mdata_o;

    exp_t        sb[$];
    logic [31:0] model [2][256];
    int          vecs  = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.DEPTH_LOG2(8), .MEM_LATENCY(2)) dut_a (
        .clk(clk), .rst(rst),
        .wregin(a_wreg), .m2regin(a_m2reg), .wmemin(a_wmem),
        .RdRtin(a_rd), .aluresultin(a_alu), .qbin(a_qb),
        .stall(a_stall), .wregout(a_wreg_o), .m2regout(a_m2reg_o),
        .RdRtout(a_rd_o), .aluresultout(a_alu_o), .mdataout(a_mdata_o),
        .misalignout(a_mis_o)
    );

    mem_access_stage #(.DEPTH_LOG2(8), .MEM_LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .wregin(b_wreg), .m2regin(b_m2reg), .wmemin(b_wmem),
        .RdRtin(b_rd), .aluresultin(b_alu), .qbin(b_qb),
        .stall(b_stall), .wregout(b_wreg_o), .m2regout(b_m2reg_o),
        .RdRtout(b_rd_o), .aluresultout(b_alu_o), .mdataout(b_mdata_o),
        .misalignout(b_mis_o)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic wreg, input logic m2reg, input logic wmem,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] qb);
        if (sel == 0) begin
            a_wreg = wreg; a_m2reg = m2reg; a_wmem = wmem; a_rd = rd; a_alu = alu; a_qb = qb;
        end else begin
            b_wreg = wreg; b_m2reg = m2reg; b_wmem = wmem; b_rd = rd; b_alu = alu; b_qb = qb;
        end
    endtask

    task automatic sample(input int sel, output exp_t o, output logic st);
        if (sel == 0) begin
            o = '{a_wreg_o, a_m2reg_o, a_rd_o, a_alu_o, a_mdata_o, a_mis_o};
            st = a_stall;
        end else begin
            o = '{b_wreg_o, b_m2reg_o, b_rd_o, b_alu_o, b_mdata_o, b_mis_o};
            st = b_stall;
        end
    endtask

    // Issue one instruction, check stall/bubbles while it is held, then check MEM/WB.
    task automatic issue(input int sel, input logic wreg, input logic m2reg, input logic wmem,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] qb,
                         input string tag);
        exp_t       e;
        exp_t       o;
        logic       st;
        int         cyc;
        int         lat;
        logic [7:0] idx;
        lat   = (sel == 0) ? 2 : 1;
        idx   = alu[9:2];
        e.wreg  = wreg;
        e.m2reg = m2reg;
        e.rd    = rd;
        e.alu   = alu;
        e.mdata = m2reg ? model[sel][idx] : 32'd0;
        e.mis   = (m2reg | wmem) & (alu[1:0] != 2'b00);
        if (wmem) model[sel][idx] = qb;
        sb.push_back(e);
        drive(sel, wreg, m2reg, wmem, rd, alu, qb);
        cyc = 0;
        #1;
        sample(sel, o, st);
        while (st === 1'b1 && cyc < 20) begin
            cyc++;
            @(posedge clk); #1;
            sample(sel, o, st);
            chk({tag, "_bubble"}, 80'(o), 80'(0));
        end
        chk({tag, "_stall_cycles"}, 80'(cyc), 80'((m2reg | wmem) ? lat - 1 : 0));
        @(posedge clk); #1;
        sample(sel, o, st);
        e = sb.pop_front();
        chk({tag, "_wregout"},      80'(o.wreg),  80'(e.wreg));
        chk({tag, "_m2regout"},     80'(o.m2reg), 80'(e.m2reg));
        chk({tag, "_RdRtout"},      80'(o.rd),    80'(e.rd));
        chk({tag, "_aluresultout"}, 80'(o.alu),   80'(e.alu));
        chk({tag, "_mdataout"},     80'(o.mdata), 80'(e.mdata));
        chk({tag, "_misalignout"},  80'(o.mis),   80'(e.mis));
    endtask

    initial begin
        exp_t o;
        logic st;
        rst = 1'b1;
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        drive(1, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        sample(0, o, st);
        chk("reset_a_outputs", 80'(o), 80'(0));
        chk("reset_a_stall", 80'(st), 80'(0));
        sample(1, o, st);
        chk("reset_b_outputs", 80'(o), 80'(0));
        rst = 1'b0;

        // MEM_LATENCY=2 instance
        issue(0, 0, 0, 1, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF, "store_10");
        issue(0, 1, 1, 0, 5'd5, 32'h0000_0010, 32'h0,         "load_10");
        issue(0, 1, 0, 0, 5'd3, 32'h0000_1234, 32'h0,         "alu_op");
        issue(0, 1, 0, 0, 5'd7, 32'h0000_1237, 32'h0,         "alu_low_bits");
        issue(0, 1, 1, 0, 5'd9, 32'h0000_0412, 32'h0,         "load_alias_412");
        issue(0, 0, 0, 1, 5'd0, 32'h0000_0020, 32'h1111_2222, "store_20");

        // Store cut off by reset in its BUSY cycle; the write must not land.
        drive(0, 0, 0, 1, 5'd0, 32'h0000_0020, 32'hCAFE_F00D);
        #1;
        sample(0, o, st);
        chk("rst_store_stall_idle", 80'(st), 80'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        sample(0, o, st);
        chk("rst_store_stall_busy", 80'(st), 80'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        #1;
        sample(0, o, st);
        chk("rst_store_outputs", 80'(o), 80'(0));
        chk("rst_store_stall_after", 80'(st), 80'(0));
        @(posedge clk); #1;

        issue(0, 1, 1, 0, 5'd4,  32'h0000_0020, 32'h0,         "load_20_after_rst");
        issue(0, 1, 1, 1, 5'd6,  32'h0000_0011, 32'h55AA_55AA, "load_store_same");
        issue(0, 1, 1, 0, 5'd8,  32'h0000_0010, 32'h0,         "load_10_new");
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);

        // MEM_LATENCY=1 instance: alternating store/load, never stalls
        issue(1, 0, 0, 1, 5'd0, 32'h0000_0008, 32'h0102_0304, "l1_store_a");
        issue(1, 1, 1, 0, 5'd2, 32'h0000_0008, 32'h0,         "l1_load_a");
        issue(1, 0, 0, 1, 5'd0, 32'h0000_0008, 32'hA5A5_0F0F, "l1_store_b");
        issue(1, 1, 1, 0, 5'd1, 32'h0000_0008, 32'h0,         "l1_load_b");
        drive(1, 0, 0, 0, 5'd0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
